// File: rtl/seg_limit_arbiter_if.sv
// Bundle between the two limit-check requesters, the limit programming port and the exception unit.
interface seg_limit_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int LIMIT_W = 20
);
    logic               r_req;
    logic [2:0]         r_seg;
    logic [1:0]         r_size;
    logic [ADDR_W-1:0]  r_ea;
    logic               r_gnt;
    logic               r_done;
    logic               r_exc;

    logic               w_req;
    logic [2:0]         w_seg;
    logic [1:0]         w_size;
    logic [ADDR_W-1:0]  w_ea;
    logic               w_gnt;
    logic               w_done;
    logic               w_exc;

    logic               flush;
    logic               lim_we;
    logic [2:0]         lim_sel;
    logic [LIMIT_W-1:0] lim_data;

    logic               fault_v;
    logic               fault_src;
    logic [2:0]         fault_seg;
    logic [ADDR_W-1:0]  fault_ea;
    logic               fault_ack;

    modport master (
        output r_req, r_seg, r_size, r_ea,
        output w_req, w_seg, w_size, w_ea,
        output flush, lim_we, lim_sel, lim_data, fault_ack,
        input  r_gnt, r_done, r_exc,
        input  w_gnt, w_done, w_exc,
        input  fault_v, fault_src, fault_seg, fault_ea
    );

    modport slave (
        input  r_req, r_seg, r_size, r_ea,
        input  w_req, w_seg, w_size, w_ea,
        input  flush, lim_we, lim_sel, lim_data, fault_ack,
        output r_gnt, r_done, r_exc,
        output w_gnt, w_done, w_exc,
        output fault_v, fault_src, fault_seg, fault_ea
    );
endinterface

// File: rtl/seg_limit_arbiter.sv
// Round-robin shared segment-limit checker for the read and write stages, with a
// two-stage compare pipeline and a sticky first-fault latch for the exception unit.
module seg_limit_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LIMIT_W = 20,
    parameter bit RR_INIT = 1'b1
) (
    input logic clk,
    input logic rst_n,
    seg_limit_arbiter_if.slave bus
);
    localparam int SUM_W = ADDR_W + 1;

    // SS is never checked and its writes are dropped, so it needs no storage.
    logic [LIMIT_W-1:0] lim_es, lim_cs, lim_ds, lim_fs, lim_gs;
    logic               rr_ptr;
    logic               gnt_r, gnt_w, tie;

    logic               s1_v, s1_src;
    logic [2:0]         s1_seg;
    logic [1:0]         s1_size;
    logic [ADDR_W-1:0]  s1_ea;

    logic               s2_src;
    logic [2:0]         s2_seg;
    logic [ADDR_W-1:0]  s2_ea;
    logic               r_done, r_exc, w_done, w_exc;

    logic               fault_v, fault_src;
    logic [2:0]         fault_seg;
    logic [ADDR_W-1:0]  fault_ea;

    logic [LIMIT_W-1:0] seg_lim;
    logic               seg_checked;
    logic [SUM_W-1:0]   ea_end;
    logic               s1_exc;
    logic               s2_fault;

    assign tie   = bus.r_req & bus.w_req & ~bus.flush;
    assign gnt_r = rst_n & ~bus.flush & bus.r_req & (~bus.w_req | ~rr_ptr);
    assign gnt_w = rst_n & ~bus.flush & bus.w_req & (~bus.r_req | rr_ptr);

    always_comb begin
        seg_lim     = '0;
        seg_checked = 1'b1;
        case (s1_seg)
            3'b000:  seg_lim = lim_es;
            3'b001:  seg_lim = lim_cs;
            3'b011:  seg_lim = lim_ds;
            3'b100:  seg_lim = lim_fs;
            3'b101:  seg_lim = lim_gs;
            default: seg_checked = 1'b0;
        endcase
    end

    // Last byte touched, one bit wider so a wrap past 2^ADDR_W still faults.
    assign ea_end   = {1'b0, s1_ea} + SUM_W'((4'd1 << s1_size) - 4'd1);
    assign s1_exc   = seg_checked & (ea_end > SUM_W'(seg_lim));
    assign s2_fault = (r_done & r_exc) | (w_done & w_exc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lim_es    <= LIMIT_W'(20'h003ff);
            lim_cs    <= LIMIT_W'(20'h04fff);
            lim_ds    <= LIMIT_W'(20'h011ff);
            lim_fs    <= LIMIT_W'(20'h003ff);
            lim_gs    <= LIMIT_W'(20'h007ff);
            rr_ptr    <= RR_INIT;
            s1_v      <= 1'b0;
            s1_src    <= 1'b0;
            s1_seg    <= '0;
            s1_size   <= '0;
            s1_ea     <= '0;
            s2_src    <= 1'b0;
            s2_seg    <= '0;
            s2_ea     <= '0;
            r_done    <= 1'b0;
            r_exc     <= 1'b0;
            w_done    <= 1'b0;
            w_exc     <= 1'b0;
            fault_v   <= 1'b0;
            fault_src <= 1'b0;
            fault_seg <= '0;
            fault_ea  <= '0;
        end else begin
            if (bus.lim_we) begin
                case (bus.lim_sel)
                    3'b000:  lim_es <= bus.lim_data;
                    3'b001:  lim_cs <= bus.lim_data;
                    3'b011:  lim_ds <= bus.lim_data;
                    3'b100:  lim_fs <= bus.lim_data;
                    3'b101:  lim_gs <= bus.lim_data;
                    default: ;
                endcase
            end

            if (tie)
                rr_ptr <= ~rr_ptr;

            s1_v <= gnt_r | gnt_w;
            if (gnt_r | gnt_w) begin
                s1_src  <= gnt_w;
                s1_seg  <= gnt_w ? bus.w_seg  : bus.r_seg;
                s1_size <= gnt_w ? bus.w_size : bus.r_size;
                s1_ea   <= gnt_w ? bus.w_ea   : bus.r_ea;
            end

            r_done <= s1_v & ~bus.flush & ~s1_src;
            r_exc  <= s1_v & ~bus.flush & ~s1_src & s1_exc;
            w_done <= s1_v & ~bus.flush &  s1_src;
            w_exc  <= s1_v & ~bus.flush &  s1_src & s1_exc;
            s2_src <= s1_src;
            s2_seg <= s1_seg;
            s2_ea  <= s1_ea;

            // A new fault outranks a simultaneous acknowledge.
            if (s2_fault && (!fault_v || bus.fault_ack)) begin
                fault_v   <= 1'b1;
                fault_src <= s2_src;
                fault_seg <= s2_seg;
                fault_ea  <= s2_ea;
            end else if (bus.fault_ack) begin
                fault_v <= 1'b0;
            end
        end
    end

    assign bus.r_gnt     = gnt_r;
    assign bus.w_gnt     = gnt_w;
    assign bus.r_done    = r_done;
    assign bus.r_exc     = r_exc;
    assign bus.w_done    = w_done;
    assign bus.w_exc     = w_exc;
    assign bus.fault_v   = fault_v;
    assign bus.fault_src = fault_src;
    assign bus.fault_seg = fault_seg;
    assign bus.fault_ea  = fault_ea;
endmodule

// File: tb/tb_seg_limit_arbiter.sv
// Bench for seg_limit_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seg_limit_arbiter;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    seg_limit_arbiter_if #(.ADDR_W(32), .LIMIT_W(20)) bus();

    seg_limit_arbiter #(.ADDR_W(32), .LIMIT_W(20), .RR_INIT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit     src;
        int     seg;
        int     size;
        longint ea;
        int     gcyc;
        bit     exc;
    } rec_t;

    rec_t   pipe[$];
    longint m_lim[8];
    bit     m_ptr, m_fv, m_fsrc;
    int     m_fseg;
    longint m_fea;
    int     cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        m_lim[0] = 64'h003ff; m_lim[1] = 64'h04fff; m_lim[2] = 64'h04000; m_lim[3] = 64'h011ff;
        m_lim[4] = 64'h003ff; m_lim[5] = 64'h007ff; m_lim[6] = 0;        m_lim[7] = 0;
        m_ptr = 1'b1;
        m_fv = 1'b0; m_fsrc = 1'b0; m_fseg = 0; m_fea = 0;
    endtask

    function automatic bit access_faults(input int seg, input int size, input longint ea);
        longint last_byte;
        last_byte = ea + (longint'(1) << size) - 1;
        if (!(seg inside {0, 1, 3, 4, 5})) return 1'b0;
        return last_byte > m_lim[seg];
    endfunction

    task automatic model_step();
        bit   e_rg, e_wg, e_rd, e_re, e_wd, e_we, fl, rq, wq, hit;
        rec_t res, nr;
        rec_t keep[$];
        if (!rst_n) model_reset();
        fl = bus.flush; rq = bus.r_req; wq = bus.w_req;
        e_rg = 0; e_wg = 0; e_rd = 0; e_re = 0; e_wd = 0; e_we = 0; hit = 0;
        res = '{0, 0, 0, 0, 0, 0};
        if (rst_n && !fl) begin
            if (rq && wq) begin
                if (m_ptr) e_wg = 1; else e_rg = 1;
            end else begin
                e_rg = rq; e_wg = wq;
            end
        end
        foreach (pipe[i]) if (pipe[i].gcyc == cyc - 2) begin
            hit = 1; res = pipe[i];
            if (res.src) begin e_wd = 1; e_we = res.exc; end
            else         begin e_rd = 1; e_re = res.exc; end
        end
        check("r_gnt", bus.r_gnt, e_rg);
        check("w_gnt", bus.w_gnt, e_wg);
        check("r_done", bus.r_done, e_rd);
        check("w_done", bus.w_done, e_wd);
        if (e_rd) check("r_exc", bus.r_exc, e_re);
        if (e_wd) check("w_exc", bus.w_exc, e_we);
        check("fault_v", bus.fault_v, m_fv);
        check("fault_src", bus.fault_src, m_fsrc);
        check("fault_seg", bus.fault_seg, m_fseg);
        check("fault_ea", bus.fault_ea, m_fea);

        if (rst_n) begin
            if (hit && res.exc && (!m_fv || bus.fault_ack)) begin
                m_fv = 1; m_fsrc = res.src; m_fseg = res.seg; m_fea = res.ea;
            end else if (bus.fault_ack) begin
                m_fv = 0;
            end
            foreach (pipe[i]) if (pipe[i].gcyc == cyc - 1)
                pipe[i].exc = access_faults(pipe[i].seg, pipe[i].size, pipe[i].ea);
            if (bus.lim_we && (int'(bus.lim_sel) inside {0, 1, 3, 4, 5}))
                m_lim[bus.lim_sel] = longint'(bus.lim_data);
            if (fl) pipe.delete();
            keep.delete();
            foreach (pipe[i]) if (pipe[i].gcyc > cyc - 2) keep.push_back(pipe[i]);
            pipe = keep;
            if (e_rg) begin
                nr = '{0, int'(bus.r_seg), int'(bus.r_size), longint'(bus.r_ea), cyc, 0};
                pipe.push_back(nr);
            end
            if (e_wg) begin
                nr = '{1, int'(bus.w_seg), int'(bus.w_size), longint'(bus.w_ea), cyc, 0};
                pipe.push_back(nr);
            end
            if (rq && wq && !fl) m_ptr = !m_ptr;
        end
        cyc++;
    endtask

    initial model_reset();
    always @(negedge clk) model_step();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit side, input bit req, input int seg, input int size, input logic [31:0] ea);
        if (side) begin
            bus.w_req = req; bus.w_seg = 3'(seg); bus.w_size = 2'(size); bus.w_ea = ea;
        end else begin
            bus.r_req = req; bus.r_seg = 3'(seg); bus.r_size = 2'(size); bus.r_ea = ea;
        end
    endtask

    // Single uncontended request; returns in the cycle its result is visible.
    task automatic one_req(input bit side, input int seg, input int size, input logic [31:0] ea,
                           input bit exp_exc, input string nm);
        tick();
        drive(side, 1'b1, seg, size, ea);
        #1 check({nm, "_gnt"}, side ? bus.w_gnt : bus.r_gnt, 1);
        tick();
        drive(side, 1'b0, seg, size, ea);
        tick();
        check({nm, "_done"}, side ? bus.w_done : bus.r_done, 1);
        check({nm, "_exc"},  side ? bus.w_exc  : bus.r_exc,  exp_exc);
    endtask

    task automatic ack_fault(input string nm);
        tick();
        check({nm, "_fv"}, bus.fault_v, 1);
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
    endtask

    task automatic write_lim(input int sel, input logic [19:0] val);
        tick();
        bus.lim_we = 1'b1; bus.lim_sel = 3'(sel); bus.lim_data = val;
        tick();
        bus.lim_we = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        bus.flush = 0; bus.lim_we = 0; bus.lim_sel = 0; bus.lim_data = 0; bus.fault_ack = 0;
        tick();
        check("rst_r_done", bus.r_done, 0);
        check("rst_fault_v", bus.fault_v, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: DS boundary, last byte exactly at limit then one past
        one_req(0, 3, 2, 32'h000011fc, 0, "t1_inlimit");
        one_req(0, 3, 2, 32'h000011fd, 1, "t1_over");
        tick();
        check("t1_fv", bus.fault_v, 1);
        check("t1_fseg", bus.fault_seg, 3);
        check("t1_fsrc", bus.fault_src, 0);
        check("t1_fea", bus.fault_ea, 32'h000011fd);
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
        tick();
        check("t1_ack", bus.fault_v, 0);

        // 2: continuous tie, W favoured first
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                drive(0, 1, 3, 0, 32'h100);
                drive(1, 1, 0, 1, 32'h10);
                #1;
                check($sformatf("t2_wgnt%0d", k), bus.w_gnt, (k % 2 == 0));
                check($sformatf("t2_rgnt%0d", k), bus.r_gnt, (k % 2 == 1));
            end else begin
                drive(0, 0, 3, 0, 32'h100);
                drive(1, 0, 0, 1, 32'h10);
            end
            if (k >= 2) begin
                check($sformatf("t2_wdone%0d", k), bus.w_done, ((k - 2) % 2 == 0));
                check($sformatf("t2_rdone%0d", k), bus.r_done, ((k - 2) % 2 == 1));
            end
        end

        // 3: GS limit written while the access sits in S1 uses the old limit
        tick();
        drive(0, 1, 5, 0, 32'h11);
        tick();
        drive(0, 0, 5, 0, 32'h11);
        bus.lim_we = 1'b1; bus.lim_sel = 3'd5; bus.lim_data = 20'h00010;
        tick();
        bus.lim_we = 1'b0;
        check("t3_old_done", bus.r_done, 1);
        check("t3_old_exc", bus.r_exc, 0);
        one_req(0, 5, 0, 32'h11, 1, "t3_new");
        ack_fault("t3_gs");
        write_lim(2, 20'h00000);
        one_req(0, 2, 3, 32'hffffffff, 0, "t3_ss");
        one_req(1, 4, 2, 32'h000003fc, 0, "t3_fs_edge");
        one_req(1, 4, 3, 32'hffffffff, 1, "t3_fs_wrap");
        ack_fault("t3_fs");

        // 4: first fault sticks, later dropped, ack loses to a new fault
        one_req(0, 1, 0, 32'h00005000, 1, "t4_cs");
        one_req(1, 3, 0, 32'h00020000, 1, "t4_ds");
        tick();
        check("t4_keep_src", bus.fault_src, 0);
        check("t4_keep_seg", bus.fault_seg, 1);
        check("t4_keep_ea", bus.fault_ea, 32'h00005000);
        one_req(1, 0, 0, 32'h00000400, 1, "t4_es");
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
        check("t4_new_fv", bus.fault_v, 1);
        check("t4_new_src", bus.fault_src, 1);
        check("t4_new_seg", bus.fault_seg, 0);
        check("t4_new_ea", bus.fault_ea, 32'h00000400);
        ack_fault("t4_es");

        // 5: flush kills an in-flight check and blocks a same-cycle grant
        tick();
        drive(0, 1, 3, 0, 32'h0);
        #1 check("t5_gnt", bus.r_gnt, 1);
        tick();
        drive(0, 0, 3, 0, 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t5_killed", bus.r_done, 0);
        tick();
        drive(0, 1, 3, 0, 32'h0);
        bus.flush = 1'b1;
        #1 check("t5_blocked", bus.r_gnt, 0);
        tick();
        bus.flush = 1'b0;
        #1 check("t5_late_gnt", bus.r_gnt, 1);
        tick();
        drive(0, 0, 3, 0, 32'h0);
        tick();
        check("t5_late_done", bus.r_done, 1);

        // 6: reset with S1/S2 occupied; limits and pointer return to reset values
        write_lim(3, 20'h00100);
        tick();
        drive(0, 1, 3, 2, 32'h000011fc);
        tick();
        drive(0, 1, 3, 0, 32'h00000010);
        tick();
        check("t6_inflight", bus.r_done, 1);
        drive(0, 0, 3, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_done", bus.r_done, 0);
        check("t6_rst_exc", bus.r_exc, 0);
        check("t6_rst_fv", bus.fault_v, 0);
        check("t6_rst_fea", bus.fault_ea, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_no_done", bus.r_done, 0);
        one_req(0, 3, 2, 32'h000011fc, 0, "t6_lim_reset");
        tick();
        drive(0, 1, 3, 0, 32'h0);
        drive(1, 1, 3, 0, 32'h0);
        #1 check("t6_ptr_reset", bus.w_gnt, 1);
        tick();
        drive(0, 0, 3, 0, 32'h0);
        drive(1, 0, 3, 0, 32'h0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
